// File: rtl/cook_timer.sv
// Microwave cook timer: BCD mm:ss countdown with keypad entry while not running.
// Ports: clk, rst (sync, active-high), clearn (sync, active-low clear), digit_valid/digit (keypad),
//        mag_on (countdown enable), min_tens..sec_ones (BCD display), timer_done, done_pulse, running.
module cook_timer #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clearn,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       mag_on,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       done_pulse,
  output logic       running
);

  typedef enum logic [1:0] {IDLE, ARMED, RUNNING} state_t;

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(TICKS_PER_SEC - 1);

  state_t        state;
  logic [PW-1:0] prescaler;

  logic          digit_ok;
  logic [15:0]   shifted;
  logic          shift_zero;
  logic [3:0]    dec_mt, dec_mo, dec_st, dec_so;
  logic          dec_zero;
  logic          tick;

  // Keypad digits are ignored while the magnetron is counting down.
  assign digit_ok   = digit_valid && (digit <= 4'd9) && (state != RUNNING);
  assign shifted    = {min_ones, sec_tens, sec_ones, digit};
  assign shift_zero = (shifted == 16'h0000);
  assign tick       = (prescaler == PS_MAX);
  assign dec_zero   = ({dec_mt, dec_mo, dec_st, dec_so} == 16'h0000);

  // BCD borrow chain. Seconds-tens wraps to 5, not 9; entered values of 6..9
  // in seconds-tens simply count down from there.
  always_comb begin
    dec_mt = min_tens;
    dec_mo = min_ones;
    dec_st = sec_tens;
    dec_so = sec_ones - 4'd1;
    if (sec_ones == 4'd0) begin
      dec_so = 4'd9;
      if (sec_tens != 4'd0) begin
        dec_st = sec_tens - 4'd1;
      end else begin
        dec_st = 4'd5;
        if (min_ones != 4'd0) begin
          dec_mo = min_ones - 4'd1;
        end else begin
          dec_mo = 4'd9;
          dec_mt = min_tens - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
      timer_done <= 1'b1;
      done_pulse <= 1'b0;
      running    <= 1'b0;
      prescaler  <= '0;
      state      <= IDLE;
    end else if (!clearn) begin
      // A clear is not an end of cook, so it never beeps.
      {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
      timer_done <= 1'b1;
      done_pulse <= 1'b0;
      running    <= 1'b0;
      prescaler  <= '0;
      state      <= IDLE;
    end else begin
      done_pulse <= 1'b0;
      if (digit_ok) begin
        // Shifting can also drop the only non-zero digit (e.g. 10:00 + "0").
        {min_tens, min_ones, sec_tens, sec_ones} <= shifted;
        timer_done <= shift_zero;
        state      <= shift_zero ? IDLE : ARMED;
        running    <= 1'b0;
        prescaler  <= '0;
      end else begin
        case (state)
          IDLE: begin
            prescaler <= '0;
            running   <= 1'b0;
          end
          ARMED: begin
            prescaler <= '0;
            if (mag_on) begin
              state   <= RUNNING;
              running <= 1'b1;
            end
          end
          RUNNING: begin
            if (!mag_on) begin
              // Pause: the partial second is discarded.
              state     <= ARMED;
              running   <= 1'b0;
              prescaler <= '0;
            end else if (tick) begin
              prescaler <= '0;
              {min_tens, min_ones, sec_tens, sec_ones} <= {dec_mt, dec_mo, dec_st, dec_so};
              if (dec_zero) begin
                state      <= IDLE;
                running    <= 1'b0;
                timer_done <= 1'b1;
                done_pulse <= 1'b1;
              end
            end else begin
              prescaler <= prescaler + 1'b1;
            end
          end
          default: begin
            state     <= IDLE;
            running   <= 1'b0;
            prescaler <= '0;
          end
        endcase
      end
    end
  end

endmodule
